mux_nway_arb: RTL and testbench
===============================

# mux_nway_arb

Parametrised, registered N-way multiplexer with per-channel valid/ready handshake. It generalises the fixed 4-way 16-bit select mux to any width and channel count. It adds a round-robin arbitration mode alongside the classic sel-driven mode. It sits between multiple word producers (ALU result, memory read, I/O) and a single consumer on the Hack data path, and registers the selected word so downstream timing is isolated.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- WAYS, 4, number of input channels (≥2; need not be a power of two)
- SELW, derived $clog2(WAYS), width of sel and out_chan
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = select mode (sel picks channel), 1 = round-robin mode
- sel  in  SELW  channel index used in select mode
- in_data  in  WAYS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  WAYS  per-channel data valid
- in_ready  out  WAYS  per-channel accept; at most one bit high per cycle
- out_data  out  WIDTH  registered selected word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data this cycle
- out_chan  out  SELW  index of channel that supplied out_data

## Operation
- load_en = !out_valid || out_ready (output register empty or draining this cycle).
- Select mode: the eligible set is channel sel only. If sel ≥ WAYS, nothing is eligible and no grant is made.
- Round-robin mode: the eligible set is every channel with in_valid. Search starts at rr_ptr and wraps modulo WAYS. The first valid channel found is granted.
- grant[i] is combinational from mode, sel, in_valid and rr_ptr.
- in_ready[i] = load_en && grant[i] && rst_n. A transfer on channel i happens when in_valid[i] && in_ready[i].
- On transfer: out_data ← channel data, out_chan ← i, out_valid ← 1.
- If load_en is high and no transfer happens: out_valid ← 0, and out_data/out_chan hold their values.
- If load_en is low: all outputs hold.
- rr_ptr update: only on a round-robin-mode transfer, rr_ptr ← (i+1) mod WAYS. This includes wrap from WAYS-1 to 0. Select-mode transfers leave rr_ptr unchanged.
- mode and sel changes are sampled combinationally. They affect the grant in the same cycle and never disturb a word already held in the output register.

## Timing
- Latency: 1 cycle from in_valid&in_ready to out_valid.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous drain and fill (out_valid && out_ready && a transfer in the same cycle): the new word replaces the old one with no bubble.
- Backpressure: out_valid=1 with out_ready=0 forces all in_ready low, and out_data is stable until accepted.
- Reset (async assert, any cycle, including mid-transfer): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, in_ready=0 while rst_n is low. Any in-flight word is dropped.
- Release: the first grant is possible on the first rising edge after rst_n goes high. Channel 0 has first priority in round-robin mode.

## Structure
- Shared package mux_pkg holds:
  - the mode encoding constants MODE_SEL=1'b0 and MODE_RR=1'b1;
  - a clog2 helper function, for tools lacking $clog2 on parameters.
- One sub-module: rr_arbiter (parameter WAYS).
  - Inputs: req[WAYS], ptr[SELW].
  - Outputs: one-hot grant and a binary grant index.
  - Purely combinational.
  - rr_ptr stays in the top module so its update rule is visible in one place.
- Top module: eligible-set logic, output register, rr_ptr register.

## Test plan
- Reset then select mode, WAYS=4, WIDTH=16, sel=2, in_data channel2=16'hBEEF with in_valid=4'b1111, out_ready=1:
  - only in_ready[2] is high;
  - next cycle out_data=16'hBEEF, out_chan=2, out_valid=1.
- Round-robin with all four channels valid continuously and out_ready=1:
  - grants go 0,1,2,3,0 on consecutive cycles;
  - out_chan follows one cycle later with no bubbles.
- Backpressure: out_valid=1 holding 16'h1234 and out_ready=0 for 3 cycles:
  - in_ready=0000 throughout, out_data stays 16'h1234;
  - on the cycle out_ready rises, the next word loads with no gap.
- WAYS=3 with sel=3 in select mode:
  - no in_ready ever asserts and out_valid falls to 0 after the drain;
  - switching mode to 1 grants a valid channel that same cycle.
- Assert rst_n low mid-stream, while out_valid=1 and rr_ptr=2:
  - out_valid=0, out_data=0, out_chan=0 and in_ready=0 immediately, without waiting for a clock edge;
  - after release, round-robin grants channel 0 first.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: mode encodings and a clog2 helper shared by the mux/arbiter slice
package mux_pkg;
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SELW = clog2(WAYS)
) (
    input  logic [WAYS-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [WAYS-1:0] gnt,
    output logic [SELW-1:0] idx
);
    logic hit;
    int   best;

    // lowest rotated distance from ptr wins; ptr is always < WAYS
    always_comb begin
        hit  = 1'b0;
        best = WAYS;
        idx  = '0;
        gnt  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (req[i] && ((i + WAYS - int'(ptr)) % WAYS) < best) begin
                best = (i + WAYS - int'(ptr)) % WAYS;
                idx  = SELW'(i);
                hit  = 1'b1;
            end
        end
        for (int i = 0; i < WAYS; i++) gnt[i] = hit && (idx == SELW'(i));
    end
endmodule

// File: rtl/mux_nway_arb.sv
// mux_nway_arb: registered N-way mux with select or round-robin valid/ready arbitration
module mux_nway_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WAYS  = 4,
    parameter int SELW  = clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_chan
);
    logic             valid_q, valid_d, load_en, xfer;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d, ptr_q, ptr_d, rr_idx;
    logic [WAYS-1:0]  grant, rr_gnt, sel_gnt;

    rr_arbiter #(.WAYS(WAYS), .SELW(SELW)) u_arb (
        .req(in_valid),
        .ptr(ptr_q),
        .gnt(rr_gnt),
        .idx(rr_idx)
    );

    always_comb begin
        load_en = !valid_q || out_ready;
        sel_gnt = '0;
        for (int i = 0; i < WAYS; i++) sel_gnt[i] = (int'(sel) == i);
        grant    = (mode == MODE_RR) ? rr_gnt : sel_gnt;
        in_ready = (load_en && rst_n) ? grant : '0;
        xfer     = 1'b0;
        data_d   = data_q;
        chan_d   = chan_q;
        for (int i = 0; i < WAYS; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                xfer   = 1'b1;
                data_d = in_data[i*WIDTH +: WIDTH];
                chan_d = SELW'(i);
            end
        end
        valid_d = load_en ? xfer : valid_q;
        ptr_d   = (xfer && mode == MODE_RR) ? ((rr_idx == SELW'(WAYS-1)) ? '0 : rr_idx + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_chan  = chan_q;
endmodule

// File: tb/tb_mux_nway_arb.sv
// tb_mux_nway_arb: table-driven checks of the 4-way instance plus backpressure, reset and 3-way sequences
module tb_mux_nway_arb;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mode, out_ready, out_valid;
    logic [1:0]  sel, out_chan;
    logic [63:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [15:0] out_data;

    logic        m3, or3, ov3;
    logic [1:0]  s3, oc3;
    logic [47:0] d3;
    logic [2:0]  iv3, rdy3;
    logic [15:0] od3;

    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mux_nway_arb #(.WIDTH(16), .WAYS(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    mux_nway_arb #(.WIDTH(16), .WAYS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(m3), .sel(s3), .in_data(d3),
        .in_valid(iv3), .in_ready(rdy3), .out_data(od3),
        .out_valid(ov3), .out_ready(or3), .out_chan(oc3)
    );

    typedef struct packed {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  oc;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // channel data: ch0=D000 ch1=D001 ch2=BEEF ch3=D003
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hD000, 2'd0};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hD001, 2'd1};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hD000, 2'd0};
        tbl[6]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hD000, 2'd0};
        tbl[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3};
        tbl[8]  = '{1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'hD003, 2'd3};
        tbl[9]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 16'hD001, 2'd1};
        tbl[10] = '{1'b1, 2'd0, 4'b1110, 1'b1, 4'b0010, 1'b1, 16'hD001, 2'd1};
        tbl[11] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3};
        tbl[12] = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b1000, 1'b1, 16'hD003, 2'd3};
        tbl[13] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[14] = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, 16'hBEEF, 2'd2};

        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {16'hD003, 16'hBEEF, 16'hD001, 16'hD000};
        m3 = 1'b0; s3 = 2'd0; iv3 = 3'b000; or3 = 1'b1;
        d3 = {16'hC002, 16'hC001, 16'hC000};

        #12;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_data", 32'(out_data), 0);
        chk("reset out_chan", 32'(out_chan), 0);
        chk("reset in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            #2;
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
            chk($sformatf("row%0d out_chan", i), 32'(out_chan), 32'(tbl[i].oc));
        end

        // backpressure: park 1234, stall 3 cycles, then release onto a fresh word
        in_data[15:0] = 16'h1234; mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        tick();
        chk("bp load", 32'(out_data), 32'h1234);
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 0);
            tick();
            chk($sformatf("bp%0d out_data", c), 32'(out_data), 32'h1234);
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 1);
        end
        in_data[15:0] = 16'h5678; out_ready = 1'b1;
        #2;
        chk("bp release in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("bp release out_data", 32'(out_data), 32'h5678);
        chk("bp release out_valid", 32'(out_valid), 1);

        // rr_ptr now 1: one more rr grant leaves out_valid=1 and rr_ptr=2
        tick();
        chk("pre-reset out_chan", 32'(out_chan), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 0);
        chk("async out_data", 32'(out_data), 0);
        chk("async out_chan", 32'(out_chan), 0);
        chk("async in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("post-reset out_chan", 32'(out_chan), 0);
        chk("post-reset out_data", 32'(out_data), 32'h5678);
        in_valid = 4'b0000;

        // 3-way instance: out-of-range sel, then live switch to round-robin
        m3 = 1'b0; s3 = 2'd1; iv3 = 3'b111; or3 = 1'b1;
        #2;
        chk("w3 sel1 in_ready", 32'(rdy3), 32'b010);
        tick();
        chk("w3 sel1 out_data", 32'(od3), 32'hC001);
        s3 = 2'd3;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk($sformatf("w3 sel3 in_ready%0d", c), 32'(rdy3), 0);
            tick();
            chk($sformatf("w3 sel3 out_valid%0d", c), 32'(ov3), 0);
        end
        m3 = 1'b1;
        #2;
        chk("w3 rr in_ready", 32'(rdy3), 32'b001);
        tick();
        chk("w3 rr out_chan0", 32'(oc3), 0);
        chk("w3 rr out_valid", 32'(ov3), 1);
        tick();
        chk("w3 rr out_chan1", 32'(oc3), 1);
        tick();
        chk("w3 rr out_chan2", 32'(oc3), 2);
        tick();
        chk("w3 rr wrap out_chan", 32'(oc3), 0);
        chk("w3 rr wrap out_data", 32'(od3), 32'hC000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
